instr_fetch_queue: RTL and testbench

Fetch stage ahead of the single-cycle datapath's decode/register-file stage. Issues sequential word fetches to instruction memory and buffers returned words in a small in-order prefetch queue. Presents instruction and PC to decode through a valid/ready handshake. Accepts a branch redirect from the PC-source selection and discards stale in-flight fetches.

---
 rtl/instr_fetch_queue.sv | 235 +++++++++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction prefetch ahead of decode.
// Issues word fetches under a credit limit of DEPTH (queued + in-flight).
// Buffers in-order responses with their fetch PC in a small queue.
// Hands instructions to decode over a valid/ready pair.
// A branch redirect flushes the queue and drains stale in-flight words.
// Optional: define FETCH_PERF_EN to add perf_fetched_o / perf_dropped_o counters.
`timescale 1ns/1ps

module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        proto_err_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_dropped_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  // Word-align a redirect target; the two byte-offset bits are discarded.
  function automatic logic [31:0] align_pc(input logic [29:0] word_addr);
    return {word_addr, 2'b00};
  endfunction

  // Sequential successor of a fetch address, wrapping modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [PTR_W-1:0] q_rd_q, q_wr_q;
  logic [PTR_W-1:0] pcq_rd_q, pcq_wr_q;
  logic             proto_err_q;

  logic [31:0]      q_instr [DEPTH];
  logic [31:0]      q_pc    [DEPTH];
  logic [31:0]      pcq     [DEPTH];

  logic             head_valid;
  logic             pop;
  logic             resp_ok;
  logic             req;
  logic             push;
  logic             discard;
  logic             flush;
  logic [CNT_W:0]   credit_used;
  logic [CNT_W-1:0] occ_after_pop;

  // Byte-offset bits of the redirect target carry no information.
  logic             unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  assign head_valid    = (occ_q != '0);
  assign pop           = head_valid & instr_ready_i;
  assign resp_ok       = imem_rvalid_i & (outst_q != '0);
  assign occ_after_pop = occ_q - CNT_W'(pop);
  assign credit_used   = {1'b0, occ_after_pop} + {1'b0, outst_q};

  // Next-state, request/push decisions and counter updates.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    occ_d      = occ_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    req        = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (!redirect_i) begin
          // A pop this cycle frees its slot, so a request may issue alongside it.
          req  = (credit_used < DEPTH_LIM);
          push = resp_ok;
        end
      end
      S_DRAIN: begin
        req  = 1'b0;
        push = 1'b0;
      end
      default: begin
        req  = 1'b0;
        push = 1'b0;
      end
    endcase

    if (req) begin
      fetch_pc_d = next_pc(fetch_pc_q);
    end
    outst_d = outst_q + CNT_W'(req) - CNT_W'(resp_ok);

    if (redirect_i) begin
      // Everything still in flight after this cycle's response is stale.
      flush      = 1'b1;
      fetch_pc_d = align_pc(redirect_pc_i[31:2]);
      drop_d     = outst_d;
      state_d    = (outst_d != '0) ? S_DRAIN : S_FETCH;
    end else if ((state_q == S_DRAIN) && resp_ok) begin
      drop_d = drop_q - CNT_ONE;
      if (drop_q == CNT_ONE) begin
        state_d = S_FETCH;
      end
    end

    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign discard = resp_ok & ~push;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Control state: fetch address, occupancy/credit counters, pointers, error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q  <= RESET_PC;
      occ_q       <= '0;
      outst_q     <= '0;
      drop_q      <= '0;
      q_rd_q      <= '0;
      q_wr_q      <= '0;
      pcq_rd_q    <= '0;
      pcq_wr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      if (req) begin
        pcq_wr_q <= pcq_wr_q + PTR_ONE;
      end
      if (resp_ok) begin
        pcq_rd_q <= pcq_rd_q + PTR_ONE;
      end
      if (push) begin
        q_wr_q <= q_wr_q + PTR_ONE;
      end
      if (flush) begin
        q_rd_q <= q_wr_q;
      end else if (pop) begin
        q_rd_q <= q_rd_q + PTR_ONE;
      end
      if (imem_rvalid_i && (outst_q == '0)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  // Queue and PC-FIFO storage; contents are qualified by the pointers above.
  always_ff @(posedge clk_i) begin
    if (req) begin
      pcq[pcq_wr_q] <= fetch_pc_q;
    end
    if (push) begin
      q_instr[q_wr_q] <= imem_rdata_i;
      q_pc[q_wr_q]    <= pcq[pcq_rd_q];
    end
  end

  assign imem_req_o    = req & ~rst_i;
  assign imem_addr_o   = imem_req_o ? fetch_pc_q : 32'h0;
  assign instr_valid_o = head_valid & ~rst_i;
  assign instr_o       = instr_valid_o ? q_instr[q_rd_q] : 32'h0;
  assign instr_pc_o    = instr_valid_o ? q_pc[q_rd_q] : 32'h0;
  assign proto_err_o   = proto_err_q & ~rst_i;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_dropped_q;
  logic [31:0] flushed_cnt;

  // Entries flushed by a redirect, excluding one delivered in the same cycle.
  assign flushed_cnt = redirect_i ? 32'(occ_after_pop) : 32'h0;

  // Delivered and discarded instruction counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetched_q <= 32'h0;
      perf_dropped_q <= 32'h0;
    end else begin
      if (pop) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      perf_dropped_q <= perf_dropped_q + flushed_cnt + 32'(discard);
    end
  end

  assign perf_fetched_o = rst_i ? 32'h0 : perf_fetched_q;
  assign perf_dropped_o = rst_i ? 32'h0 : perf_dropped_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized scoreboard bench for instr_fetch_queue.
// Driver models memory and the fetch rules at transaction level; monitor checks delivery.
`timescale 1ns/1ps

module tb_instr_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        proto_err_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_dropped_o;
`endif

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .proto_err_o   (proto_err_o)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_o(perf_fetched_o),
    .perf_dropped_o(perf_dropped_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        exp_q[$];      // words the decode side must still receive, in order
  logic [31:0] pend[$];       // addresses of requests not yet answered
  int          mem_sched[$];  // cycle numbers at which memory answers
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_t = 0;
  int          drop = 0;
  bit          mon_en = 1'b0;
  bit          m_proto = 1'b0;
  logic [31:0] m_pc = RESET_PC;
  int unsigned m_fetched = 0;
  int unsigned m_dropped = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every handshake against the scoreboard head.
  always @(negedge clk_i) begin
    ent_t e;
    #1;
    if (mon_en) begin
      chk("instr_valid", 32'(instr_valid_o), 32'(exp_q.size() != 0));
      if (instr_valid_o === 1'b1 && instr_ready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: actual=%h required=none (cycle %0d)", instr_pc_o, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("instr", instr_o, e.instr);
          chk("instr_pc", instr_pc_o, e.pc);
          m_fetched++;
        end
      end
    end
  end

  task automatic model_reset();
    exp_q.delete();
    pend.delete();
    mem_sched.delete();
    m_pc      = RESET_PC;
    drop      = 0;
    m_proto   = 1'b0;
    last_t    = cyc;
    m_fetched = 0;
    m_dropped = 0;
  endtask

  task automatic do_reset(input int n);
    mon_en        = 1'b0;
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    instr_ready_i = 1'b1;
    repeat (n) @(negedge clk_i);
    #2;
    chk("rst_req", 32'(imem_req_o), 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);
    chk("rst_proto", 32'(proto_err_o), 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched_o, 32'h0);
    chk("rst_perf_dropped", perf_dropped_o, 32'h0);
`endif
    model_reset();
    @(negedge clk_i);
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(3))
      0:       t = 32'h0000_0103;
      1:       t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      default: t = $urandom;
    endcase
    return t;
  endfunction

  // One clock cycle: drive inputs, then check and advance the reference model.
  task automatic run_cycle(input int ready_pct, input bit allow_redir, input bit spurious);
    bit          rv;
    bit          exp_req;
    int          t;
    logic [31:0] p;
    rst_i         = 1'b0;
    mon_en        = 1'b1;
    instr_ready_i = ($urandom_range(99) < ready_pct);
    redirect_i    = allow_redir && ($urandom_range(15) == 0);
    redirect_pc_i = pick_target();
    rv = (mem_sched.size() > 0) && (mem_sched[0] <= cyc);
    if (rv) void'(mem_sched.pop_front());
    if (spurious && (mem_sched.size() == 0)) rv = 1'b1;
    imem_rvalid_i = rv;
    imem_rdata_i  = $urandom;
    #2;
    exp_req = !redirect_i && (drop == 0) && ((exp_q.size() + pend.size()) < DEPTH);
    chk("imem_req", 32'(imem_req_o), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr_o, m_pc);
    chk("proto_err", 32'(proto_err_o), 32'(m_proto));
    if (imem_req_o === 1'b1) begin
      t = cyc + int'($urandom_range(1, 3));
      if (t <= last_t) t = last_t + 1;
      last_t = t;
      mem_sched.push_back(t);
    end
    if (rv) begin
      if (pend.size() == 0) begin
        m_proto = 1'b1;
      end else begin
        p = pend.pop_front();
        if (redirect_i || drop > 0) begin
          if (drop > 0) drop--;
          m_dropped++;
        end else begin
          exp_q.push_back('{instr: imem_rdata_i, pc: p});
        end
      end
    end
    if (redirect_i) begin
      m_dropped += exp_q.size();
      exp_q.delete();
      m_pc = {redirect_pc_i[31:2], 2'b00};
      drop = pend.size();
    end
    if (exp_req) begin
      pend.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    cyc++;
    @(negedge clk_i);
  endtask

  function automatic int pick_ready();
    case ($urandom_range(3))
      0:       return 0;
      1:       return 30;
      2:       return 70;
      default: return 100;
    endcase
  endfunction

  initial begin
    rst_i = 1'b1;
    do_reset(3);

    // Streaming with all-ready first, then mixed backpressure and redirects.
    repeat (30) run_cycle(100, 1'b0, 1'b0);
    for (int seg = 0; seg < 30; seg++) begin
      int pct;
      pct = pick_ready();
      repeat (50) run_cycle(pct, 1'b1, 1'b0);
    end

    // Fill the queue with decode stalled, then send a response nobody asked for.
    repeat (20) run_cycle(0, 1'b0, 1'b0);
    run_cycle(0, 1'b0, 1'b1);
    repeat (20) run_cycle(100, 1'b0, 1'b0);
    chk("proto_sticky", 32'(proto_err_o), 32'h1);

`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched_o, m_fetched);
    chk("perf_dropped", perf_dropped_o, m_dropped);
`endif

    // Reset mid-operation clears the error flag and all in-flight state.
    do_reset(2);
    for (int seg = 0; seg < 6; seg++) begin
      int pct;
      pct = pick_ready();
      repeat (40) run_cycle(pct, 1'b1, 1'b0);
    end
    repeat (20) run_cycle(100, 1'b0, 1'b0);

`ifdef FETCH_PERF_EN
    chk("perf_fetched_end", perf_fetched_o, m_fetched);
    chk("perf_dropped_end", perf_dropped_o, m_dropped);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
